mos_switch_bank: RTL and testbench
==================================

// Module: mos_switch_bank
// PURPOSE
// - Synthesizable 4-state model of a bank of Verilog nmos/pmos switch primitives; every channel has one nmos and one pmos.
// - Computes switch-level drain values combinationally.
// - Also provides clock-sampled copies and change strobes, so logic-simulation exercises can observe switch behaviour.
// - Sits in the arch study/teaching harness and replaces the built-in primitives where 4-state values must be carried on plain vectors.
// PARAMETERS
// - N_CH  1  number of independent switch channels
// PORTS
// - clk        in   1         single clock; all registers on rising edge
// - rst        in   1         asynchronous, active-high reset
// - src        in   2*N_CH    per-channel source value (logic4_t)
// - gate       in   2*N_CH    per-channel gate value (logic4_t)
// - drain_n    out  2*N_CH    combinational nmos drain
// - drain_p    out  2*N_CH    combinational pmos drain
// - drain_n_q  out  2*N_CH    drain_n registered on clk
// - drain_p_q  out  2*N_CH    drain_p registered on clk
// - chg_n      out  N_CH      1-cycle strobe: drain_n_q[i] changed on this edge
// - chg_p      out  N_CH      1-cycle strobe: drain_p_q[i] changed on this edge
// BEHAVIOUR
// - Encoding logic4_t, 2 bits: 2'b00=0, 2'b01=1, 2'b10=Z, 2'b11=X. Channel i occupies bits [2i+1:2i].
// - nmos drain (combinational, no clock involvement):
//   - gate=1: drain=src, except src=Z gives Z.
//   - gate=0: drain=Z.
//   - gate=X or Z: src=Z gives Z; every other src gives X (the L/H strengths of the primitive collapse to X).
// - pmos drain: same table with gate polarity inverted.
//   - gate=0 passes src.
//   - gate=1 gives Z.
//   - gate X/Z follows the nmos rule.
// - Strength reduction (supply->strong) is not modelled; all outputs are plain 4-state values.
// - Registered path: each clk rising edge loads drain_n_q<=drain_n and drain_p_q<=drain_p.
//   - chg_* = (new value != previous registered value), registered in the same cycle.
//   - Latency: exactly 1 cycle from input to *_q outputs.
// - Reset (async assert, released synchronously into the next edge):
//   - drain_n_q=drain_p_q=Z for all channels; chg_n=chg_p=0.
//   - Combinational drains are unaffected by rst.
// - First edge after reset: chg_* compares against Z, so a non-Z drain strobes.
// - Reset asserted mid-operation forces the reset values immediately, independent of clk.
// - Channels are fully independent; no shared nets and no wired resolution between channels.
// STRUCTURE
// - Package mos_pkg holds:
//   - typedef logic4_t with constants L4_0, L4_1, L4_Z, L4_X
//   - function nmos_eval(src,gate)
//   - function pmos_eval(src,gate), implemented as nmos_eval with the gate inverted (0<->1; X and Z unchanged)
// - Sub-module mos_switch_cell: one channel (comb eval, 2 regs, 2 strobes).
//   - The top generate-loops N_CH instances.
// TESTING
// - pmos, gate=0: src=0 -> drain_p=0; src=1 -> drain_p=1. gate=1 with src 0 or 1 -> drain_p=Z.
// - nmos, gate=0: src=0 or 1 -> drain_n=Z. gate=1: src=0 -> drain_n=0; src=1 -> drain_n=1.
// - Gate X/Z: src=1, gate=X -> both drains X; src=Z, gate=Z -> both drains Z.
// - Registered path: after rst, *_q=Z and chg=0. Apply src=1, gate=1 -> next edge drain_n_q=1, chg_n=1; following edge chg_n=0.
// - Mid-run reset: assert rst between edges -> *_q=Z and chg=0 immediately, while the comb drains still track the inputs.
// - N_CH=4: drive distinct src/gate per channel and check each channel against the truth table with no cross-talk.

Source files
------------

// File: rtl/mos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mos_pkg
// Description : 4-state value encoding and nmos/pmos switch evaluation helpers
// Revision    : 1.0 - initial release
// ============================================================================
package mos_pkg;

    typedef logic [1:0] logic4_t;

    localparam logic4_t L4_0 = 2'b00;
    localparam logic4_t L4_1 = 2'b01;
    localparam logic4_t L4_Z = 2'b10;
    localparam logic4_t L4_X = 2'b11;

    // An undetermined gate over a driven source gives L or H, collapsed to X.
    function automatic logic4_t nmos_eval(input logic4_t src, input logic4_t gate);
        logic4_t drain;
        drain = L4_X;
        if (src == L4_Z) begin
            drain = L4_Z;
        end else begin
            case (gate)
                L4_1:    drain = src;
                L4_0:    drain = L4_Z;
                default: drain = L4_X;
            endcase
        end
        return drain;
    endfunction

    function automatic logic4_t invert_gate(input logic4_t gate);
        logic4_t inv;
        case (gate)
            L4_0:    inv = L4_1;
            L4_1:    inv = L4_0;
            default: inv = gate;
        endcase
        return inv;
    endfunction

    function automatic logic4_t pmos_eval(input logic4_t src, input logic4_t gate);
        return nmos_eval(src, invert_gate(gate));
    endfunction

endpackage : mos_pkg
`default_nettype wire

// File: rtl/mos_switch_cell.sv
`default_nettype none
// ============================================================================
// Module      : mos_switch_cell
// Description : one nmos/pmos channel with registered drains and change strobes
// Revision    : 1.0 - initial release
// ============================================================================
module mos_switch_cell
    import mos_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] src,
    input  logic [1:0] gate,
    output logic [1:0] drain_n,
    output logic [1:0] drain_p,
    output logic [1:0] drain_n_q,
    output logic [1:0] drain_p_q,
    output logic       chg_n,
    output logic       chg_p
);

    always_comb begin
        drain_n = nmos_eval(src, gate);
        drain_p = pmos_eval(src, gate);
    end

    // Strobes compare the incoming drain with the value held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_n_q <= L4_Z;
            drain_p_q <= L4_Z;
            chg_n     <= 1'b0;
            chg_p     <= 1'b0;
        end else begin
            drain_n_q <= drain_n;
            drain_p_q <= drain_p;
            chg_n     <= (drain_n != drain_n_q);
            chg_p     <= (drain_p != drain_p_q);
        end
    end

endmodule : mos_switch_cell
`default_nettype wire

// File: rtl/mos_switch_bank.sv
`default_nettype none
// ============================================================================
// Module      : mos_switch_bank
// Description : bank of N_CH independent 4-state nmos/pmos switch channels
// Revision    : 1.0 - initial release
// ============================================================================
module mos_switch_bank
    import mos_pkg::*;
#(
    parameter int N_CH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*N_CH-1:0] src,
    input  logic [2*N_CH-1:0] gate,
    output logic [2*N_CH-1:0] drain_n,
    output logic [2*N_CH-1:0] drain_p,
    output logic [2*N_CH-1:0] drain_n_q,
    output logic [2*N_CH-1:0] drain_p_q,
    output logic [N_CH-1:0]   chg_n,
    output logic [N_CH-1:0]   chg_p
);

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            mos_switch_cell u_cell (
                .clk       (clk),
                .rst       (rst),
                .src       (src[2*i+1:2*i]),
                .gate      (gate[2*i+1:2*i]),
                .drain_n   (drain_n[2*i+1:2*i]),
                .drain_p   (drain_p[2*i+1:2*i]),
                .drain_n_q (drain_n_q[2*i+1:2*i]),
                .drain_p_q (drain_p_q[2*i+1:2*i]),
                .chg_n     (chg_n[i]),
                .chg_p     (chg_p[i])
            );
        end
    endgenerate

endmodule : mos_switch_bank
`default_nettype wire

// File: tb/tb_mos_switch_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mos_switch_bank
// Description : randomized bench for a 4-channel switch bank with a table model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mos_switch_bank;

    localparam int N_CH = 4;
    localparam int W    = 2 * N_CH;

    logic          clk;
    logic          rst;
    logic [W-1:0]  src;
    logic [W-1:0]  gate;
    logic [W-1:0]  drain_n;
    logic [W-1:0]  drain_p;
    logic [W-1:0]  drain_n_q;
    logic [W-1:0]  drain_p_q;
    logic [N_CH-1:0] chg_n;
    logic [N_CH-1:0] chg_p;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    mos_switch_bank #(.N_CH(N_CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .gate      (gate),
        .drain_n   (drain_n),
        .drain_p   (drain_p),
        .drain_n_q (drain_n_q),
        .drain_p_q (drain_p_q),
        .chg_n     (chg_n),
        .chg_p     (chg_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table indexed [gate][src]; rows 0,1,Z,X for the nmos switch.
    logic [1:0] nmos_tab [4][4];
    initial begin
        nmos_tab[0] = '{2'b10, 2'b10, 2'b10, 2'b10};
        nmos_tab[1] = '{2'b00, 2'b01, 2'b10, 2'b11};
        nmos_tab[2] = '{2'b11, 2'b11, 2'b10, 2'b11};
        nmos_tab[3] = '{2'b11, 2'b11, 2'b10, 2'b11};
    end

    // pmos swaps gate rows 0 and 1.
    function automatic logic [W-1:0] bank_model(input logic [W-1:0] s,
                                                input logic [W-1:0] g,
                                                input bit is_p);
        logic [W-1:0] r;
        int gi;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            gi = int'(g[2*c +: 2]);
            if (is_p && gi < 2) gi = 1 - gi;
            r[2*c +: 2] = nmos_tab[gi][int'(s[2*c +: 2])];
        end
        return r;
    endfunction

    function automatic logic [N_CH-1:0] diff_mask(input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [N_CH-1:0] m;
        for (int c = 0; c < N_CH; c++) m[c] = (a[2*c +: 2] != b[2*c +: 2]);
        return m;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for the registered path.
    logic [W-1:0]    exp_q_n, exp_q_p;
    logic [N_CH-1:0] exp_chg_n, exp_chg_p;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q_n   <= {N_CH{2'b10}};
            exp_q_p   <= {N_CH{2'b10}};
            exp_chg_n <= '0;
            exp_chg_p <= '0;
        end else begin
            exp_q_n   <= bank_model(src, gate, 1'b0);
            exp_q_p   <= bank_model(src, gate, 1'b1);
            exp_chg_n <= diff_mask(bank_model(src, gate, 1'b0), exp_q_n);
            exp_chg_p <= diff_mask(bank_model(src, gate, 1'b1), exp_q_p);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("drain_n", drain_n, bank_model(src, gate, 1'b0));
            check("drain_p", drain_p, bank_model(src, gate, 1'b1));
            check("drain_n_q", drain_n_q, exp_q_n);
            check("drain_p_q", drain_p_q, exp_q_p);
            check("chg_n", W'(chg_n), W'(exp_chg_n));
            check("chg_p", W'(chg_p), W'(exp_chg_p));
        end
    end

    task automatic randomize_inputs();
        src  = W'($urandom);
        gate = W'($urandom);
    endtask

    initial begin
        rst  = 1'b1;
        src  = 8'h55;
        gate = 8'h55;
        repeat (2) @(posedge clk);
        #2;
        check("rst_q_n", drain_n_q, 8'hAA);
        check("rst_q_p", drain_p_q, 8'hAA);
        check("rst_chg", W'({chg_n, chg_p}), 8'h00);
        check("rst_comb_n", drain_n, 8'h55);
        check("rst_comb_p", drain_p, 8'hAA);

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("first_q_n", drain_n_q, 8'h55);
        check("first_q_p", drain_p_q, 8'hAA);
        check("first_chg_n", W'(chg_n), 8'h0F);
        check("first_chg_p", W'(chg_p), 8'h00);
        @(posedge clk); #1;
        check("second_chg_n", W'(chg_n), 8'h00);
        check("second_q_n", drain_n_q, 8'h55);

        // ch0..3: (src,gate) = (0,0) (1,0) (0,1) (1,1)
        src = 8'b01_00_01_00; gate = 8'b01_01_00_00;
        #1;
        check("tab1_n", drain_n, 8'b01_00_10_10);
        check("tab1_p", drain_p, 8'b10_10_01_00);

        // ch0..3: (1,X) (Z,Z) (X,1) (0,Z)
        src = 8'b00_11_10_01; gate = 8'b10_01_10_11;
        #1;
        check("tab2_n", drain_n, 8'b11_11_10_11);
        check("tab2_p", drain_p, 8'b11_10_10_11);

        chk_en = 1'b1;
        repeat (300) begin
            @(posedge clk); #1;
            randomize_inputs();
        end

        // Mid-run reset between edges.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_q_n", drain_n_q, 8'hAA);
        check("mid_rst_q_p", drain_p_q, 8'hAA);
        check("mid_rst_chg", W'({chg_n, chg_p}), 8'h00);
        randomize_inputs();
        #1;
        check("mid_rst_comb_n", drain_n, bank_model(src, gate, 1'b0));
        check("mid_rst_comb_p", drain_p, bank_model(src, gate, 1'b1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            randomize_inputs();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mos_switch_bank
`default_nettype wire
